// File: rtl/aq_mmu_jtlb_tag_ctrl.sv
// JTLB tag-array sequencer: arbitrates lookup / refill / invalidate-all onto the
// 64-set, 2-way tag SRAM and turns the read data into hit results and refill writes.
module aq_mmu_jtlb_tag_ctrl #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 48
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  // Every requester holds its req (and payload) until it sees its gnt in the same
  // cycle; the transfer happens on that clock edge and req may drop afterwards.
  input  logic                   lkup_req,
  input  logic [IDX_W-1:0]       lkup_idx,
  input  logic [26:0]            lkup_vpn,
  input  logic [15:0]            lkup_asid,
  output logic                   lkup_gnt,
  output logic                   lkup_rslt_vld,
  output logic                   lkup_hit,
  output logic                   lkup_hit_way,
  output logic                   lkup_multi_hit,
  output logic [TAG_W-1:0]       lkup_hit_tag,
  input  logic                   refill_req,
  input  logic [IDX_W-1:0]       refill_idx,
  input  logic [TAG_W-1:0]       refill_tag,
  output logic                   refill_gnt,
  output logic                   refill_done,
  output logic                   refill_way,
  input  logic                   inv_all_req,
  output logic                   inv_all_gnt,
  output logic                   inv_all_done,
  output logic                   ctrl_busy,
  output logic [2:0]             ctrl_state_o,
  output logic                   jtlb_tag_cen,
  output logic [8:0]             jtlb_tag_idx,
  output logic [2:0]             jtlb_tag_wen,
  output logic [2*TAG_W+1:0]     jtlb_tag_din,
  input  logic [2*TAG_W+1:0]     jtlb_tag_dout
);

  localparam int DIN_W = 2*TAG_W + 2;
  localparam logic [IDX_W-1:0] LAST_SET = '1;

  // RF_RD is the read half of a refill; it coincides with the grant cycle, so the
  // FSM itself moves straight from the granting state to RF_WR.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LK_CMP = 3'd1,
    ST_RF_RD  = 3'd2,
    ST_RF_WR  = 3'd3,
    ST_INV    = 3'd4
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [26:0]      lk_vpn_q;
  logic [15:0]      lk_asid_q;
  logic [IDX_W-1:0] rf_idx_q;
  logic [TAG_W-1:0] rf_tag_q;

  logic             lkup_rslt_vld_q;
  logic             lkup_hit_q;
  logic             lkup_hit_way_q;
  logic             lkup_multi_hit_q;
  logic [TAG_W-1:0] lkup_hit_tag_q;
  logic             refill_done_q;
  logic             refill_way_q;
  logic             inv_all_done_q;

  logic [TAG_W-1:0] dout_way0;
  logic [TAG_W-1:0] dout_way1;
  logic             dout_fifo;
  logic             unused_dout_msb;

  logic             can_gnt;
  logic [1:0]       lk_hit_d;
  logic [1:0]       rf_match_d;
  logic             rf_way_d;
  logic [TAG_W-1:0] lk_hit_tag_d;

  assign dout_way0       = jtlb_tag_dout[TAG_W-1:0];
  assign dout_way1       = jtlb_tag_dout[2*TAG_W-1:TAG_W];
  assign dout_fifo       = jtlb_tag_dout[2*TAG_W];
  assign unused_dout_msb = jtlb_tag_dout[DIN_W-1];

  // Tag layout: [47]V [46]G [45:44]PGS [43:28]ASID [27:1]VPN [0]rsvd.
  // Larger pages ignore the low VPN bits; PGS=11 behaves like PGS=10.
  function automatic logic way_hit(input logic [TAG_W-1:0] tag,
                                   input logic [26:0]      vpn,
                                   input logic [15:0]      asid);
    logic [26:0] mask;
    case (tag[45:44])
      2'b00:   mask = {27{1'b1}};
      2'b01:   mask = {{18{1'b1}}, 9'h000};
      default: mask = {{9{1'b1}}, 18'h00000};
    endcase
    return tag[47] & (tag[46] | (tag[43:28] == asid)) &
           (((tag[27:1] ^ vpn) & mask) == 27'd0);
  endfunction

  always_comb begin
    lk_hit_d[0]   = way_hit(dout_way0, lk_vpn_q, lk_asid_q);
    lk_hit_d[1]   = way_hit(dout_way1, lk_vpn_q, lk_asid_q);
    rf_match_d[0] = way_hit(dout_way0, rf_tag_q[27:1], rf_tag_q[43:28]);
    rf_match_d[1] = way_hit(dout_way1, rf_tag_q[27:1], rf_tag_q[43:28]);
    lk_hit_tag_d  = '0;
    if (lk_hit_d[0]) begin
      lk_hit_tag_d = dout_way0;
    end else if (lk_hit_d[1]) begin
      lk_hit_tag_d = dout_way1;
    end
    // Victim: re-use a matching entry, else an invalid way, else the FIFO pointer.
    if (rf_match_d[0]) begin
      rf_way_d = 1'b0;
    end else if (rf_match_d[1]) begin
      rf_way_d = 1'b1;
    end else if (!dout_way0[TAG_W-1]) begin
      rf_way_d = 1'b0;
    end else if (!dout_way1[TAG_W-1]) begin
      rf_way_d = 1'b1;
    end else begin
      rf_way_d = dout_fifo;
    end
  end

  assign can_gnt     = (state_q == ST_IDLE) || (state_q == ST_LK_CMP);
  assign inv_all_gnt = can_gnt & inv_all_req;
  assign refill_gnt  = can_gnt & refill_req & ~inv_all_req;
  assign lkup_gnt    = can_gnt & lkup_req & ~inv_all_req & ~refill_req;

  always_comb begin
    jtlb_tag_cen = 1'b0;
    jtlb_tag_idx = 9'd0;
    jtlb_tag_wen = 3'b000;
    jtlb_tag_din = '0;
    case (state_q)
      ST_RF_WR: begin
        jtlb_tag_cen = 1'b1;
        jtlb_tag_idx = 9'(rf_idx_q);
        jtlb_tag_wen = {1'b1, rf_way_d, ~rf_way_d};
        jtlb_tag_din = {1'b0, ~rf_way_d, rf_tag_q, rf_tag_q};
      end
      ST_INV: begin
        jtlb_tag_cen = 1'b1;
        jtlb_tag_idx = 9'(cnt_q);
        jtlb_tag_wen = 3'b111;
      end
      default: begin
        if (refill_gnt) begin
          jtlb_tag_cen = 1'b1;
          jtlb_tag_idx = 9'(refill_idx);
        end else if (lkup_gnt) begin
          jtlb_tag_cen = 1'b1;
          jtlb_tag_idx = 9'(lkup_idx);
        end
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      lk_vpn_q         <= '0;
      lk_asid_q        <= '0;
      rf_idx_q         <= '0;
      rf_tag_q         <= '0;
      lkup_rslt_vld_q  <= 1'b0;
      lkup_hit_q       <= 1'b0;
      lkup_hit_way_q   <= 1'b0;
      lkup_multi_hit_q <= 1'b0;
      lkup_hit_tag_q   <= '0;
      refill_done_q    <= 1'b0;
      refill_way_q     <= 1'b0;
      inv_all_done_q   <= 1'b0;
    end else begin
      lkup_rslt_vld_q <= (state_q == ST_LK_CMP);
      refill_done_q   <= (state_q == ST_RF_WR);
      inv_all_done_q  <= (state_q == ST_INV) && (cnt_q == LAST_SET);

      // The compare depends only on dout, so it retires even if a new grant leaves LK_CMP.
      if (state_q == ST_LK_CMP) begin
        lkup_hit_q       <= |lk_hit_d;
        lkup_hit_way_q   <= ~lk_hit_d[0] & lk_hit_d[1];
        lkup_multi_hit_q <= &lk_hit_d;
        lkup_hit_tag_q   <= lk_hit_tag_d;
      end
      if (state_q == ST_RF_WR) begin
        refill_way_q <= rf_way_d;
      end
      if (lkup_gnt) begin
        lk_vpn_q  <= lkup_vpn;
        lk_asid_q <= lkup_asid;
      end
      if (refill_gnt) begin
        rf_idx_q <= refill_idx;
        rf_tag_q <= refill_tag;
      end

      case (state_q)
        ST_IDLE, ST_LK_CMP: begin
          if (inv_all_gnt) begin
            state_q <= ST_INV;
          end else if (refill_gnt) begin
            state_q <= ST_RF_WR;
          end else if (lkup_gnt) begin
            state_q <= ST_LK_CMP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_INV: begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == LAST_SET) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lkup_rslt_vld  = lkup_rslt_vld_q;
  assign lkup_hit       = lkup_hit_q;
  assign lkup_hit_way   = lkup_hit_way_q;
  assign lkup_multi_hit = lkup_multi_hit_q;
  assign lkup_hit_tag   = lkup_hit_tag_q;
  assign refill_done    = refill_done_q;
  assign refill_way     = refill_way_q;
  assign inv_all_done   = inv_all_done_q;
  assign ctrl_busy      = (state_q != ST_IDLE);
  assign ctrl_state_o   = state_q;

endmodule

// File: tb/tb_aq_mmu_jtlb_tag_ctrl.sv
// Bench for aq_mmu_jtlb_tag_ctrl: behavioural tag SRAM, reference set model and
// scoreboards for lookup results and refill completions.
module tb_aq_mmu_jtlb_tag_ctrl;

  logic         forever_cpuclk;
  logic         cpurst_b;
  logic         lkup_req;
  logic [5:0]   lkup_idx;
  logic [26:0]  lkup_vpn;
  logic [15:0]  lkup_asid;
  logic         lkup_gnt, lkup_rslt_vld, lkup_hit, lkup_hit_way, lkup_multi_hit;
  logic [47:0]  lkup_hit_tag;
  logic         refill_req;
  logic [5:0]   refill_idx;
  logic [47:0]  refill_tag;
  logic         refill_gnt, refill_done, refill_way;
  logic         inv_all_req, inv_all_gnt, inv_all_done;
  logic         ctrl_busy;
  logic [2:0]   ctrl_state_o;
  logic         jtlb_tag_cen;
  logic [8:0]   jtlb_tag_idx;
  logic [2:0]   jtlb_tag_wen;
  logic [97:0]  jtlb_tag_din;
  logic [97:0]  jtlb_tag_dout;

  aq_mmu_jtlb_tag_ctrl dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .lkup_req       (lkup_req),
    .lkup_idx       (lkup_idx),
    .lkup_vpn       (lkup_vpn),
    .lkup_asid      (lkup_asid),
    .lkup_gnt       (lkup_gnt),
    .lkup_rslt_vld  (lkup_rslt_vld),
    .lkup_hit       (lkup_hit),
    .lkup_hit_way   (lkup_hit_way),
    .lkup_multi_hit (lkup_multi_hit),
    .lkup_hit_tag   (lkup_hit_tag),
    .refill_req     (refill_req),
    .refill_idx     (refill_idx),
    .refill_tag     (refill_tag),
    .refill_gnt     (refill_gnt),
    .refill_done    (refill_done),
    .refill_way     (refill_way),
    .inv_all_req    (inv_all_req),
    .inv_all_gnt    (inv_all_gnt),
    .inv_all_done   (inv_all_done),
    .ctrl_busy      (ctrl_busy),
    .ctrl_state_o   (ctrl_state_o),
    .jtlb_tag_cen   (jtlb_tag_cen),
    .jtlb_tag_idx   (jtlb_tag_idx),
    .jtlb_tag_wen   (jtlb_tag_wen),
    .jtlb_tag_din   (jtlb_tag_din),
    .jtlb_tag_dout  (jtlb_tag_dout)
  );

  // ---------------- clock / reset ----------------
  initial begin
    forever_cpuclk = 1'b0;
    forever #5 forever_cpuclk = ~forever_cpuclk;
  end

  int cyc = 0;
  always @(posedge forever_cpuclk) cyc <= cyc + 1;

  // ---------------- tag SRAM: 1-cycle read latency, per-field write enables ----------------
  logic [97:0] mem [64];
  always @(posedge forever_cpuclk) begin
    if (jtlb_tag_cen) begin
      if (jtlb_tag_wen == 3'b000) begin
        jtlb_tag_dout <= mem[jtlb_tag_idx[5:0]];
      end else begin
        if (jtlb_tag_wen[0]) mem[jtlb_tag_idx[5:0]][47:0]  <= jtlb_tag_din[47:0];
        if (jtlb_tag_wen[1]) mem[jtlb_tag_idx[5:0]][95:48] <= jtlb_tag_din[95:48];
        if (jtlb_tag_wen[2]) mem[jtlb_tag_idx[5:0]][97:96] <= jtlb_tag_din[97:96];
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference set model ----------------
  logic [47:0] m_w0 [64];
  logic [47:0] m_w1 [64];
  logic        m_fifo [64];

  function automatic logic [47:0] mk_tag(input logic g, input logic [1:0] pgs,
                                         input logic [15:0] asid, input logic [26:0] vpn);
    return {1'b1, g, pgs, asid, vpn, 1'b0};
  endfunction

  function automatic logic m_hit(input logic [47:0] t, input logic [26:0] vpn, input logic [15:0] asid);
    int low;
    case (t[45:44])
      2'b00:   low = 0;
      2'b01:   low = 9;
      default: low = 18;
    endcase
    return t[47] && (t[46] || (t[43:28] == asid)) && ((t[27:1] >> low) == (vpn >> low));
  endfunction

  // {hit, way, multi, tag}
  function automatic logic [50:0] m_lookup(input logic [5:0] idx, input logic [26:0] vpn, input logic [15:0] asid);
    logic h0, h1;
    logic [47:0] t;
    h0 = m_hit(m_w0[idx], vpn, asid);
    h1 = m_hit(m_w1[idx], vpn, asid);
    t  = h0 ? m_w0[idx] : (h1 ? m_w1[idx] : 48'd0);
    return {h0 | h1, !h0 && h1, h0 && h1, t};
  endfunction

  task automatic m_refill(input logic [5:0] idx, input logic [47:0] tag, output logic w);
    logic h0, h1;
    h0 = m_hit(m_w0[idx], tag[27:1], tag[43:28]);
    h1 = m_hit(m_w1[idx], tag[27:1], tag[43:28]);
    if (h0)                  w = 1'b0;
    else if (h1)             w = 1'b1;
    else if (!m_w0[idx][47]) w = 1'b0;
    else if (!m_w1[idx][47]) w = 1'b1;
    else                     w = m_fifo[idx];
    if (w) m_w1[idx] = tag;
    else   m_w0[idx] = tag;
    m_fifo[idx] = ~w;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 64; i++) begin
      m_w0[i] = '0;
      m_w1[i] = '0;
      m_fifo[i] = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [50:0] lk_exp_q[$];
  int          lk_cyc_q[$];
  logic [0:0]  rf_exp_q[$];
  int          rf_cyc_q[$];
  int          inv_done_cnt = 0;
  int          lk_gnt_cyc, rf_gnt_cyc, inv_gnt_cyc;

  always @(negedge forever_cpuclk) begin
    #2;
    if (cpurst_b) begin
      if (lkup_rslt_vld) begin
        if (lk_exp_q.size() == 0) begin
          check_eq("lkup_rslt_unexpected", 1, 0);
        end else begin
          check_eq("lkup_rslt", {lkup_hit, lkup_hit_way, lkup_multi_hit, lkup_hit_tag}, lk_exp_q.pop_front());
          check_eq("lkup_latency", cyc, lk_cyc_q.pop_front());
        end
      end
      if (refill_done) begin
        if (rf_exp_q.size() == 0) begin
          check_eq("refill_done_unexpected", 1, 0);
        end else begin
          check_eq("refill_way", refill_way, rf_exp_q.pop_front());
          check_eq("refill_latency", cyc, rf_cyc_q.pop_front());
        end
      end
      if (inv_all_done) inv_done_cnt++;
      if (jtlb_tag_cen) check_eq("idx_hi_zero", jtlb_tag_idx[8:6], 0);
    end
  end

  // ---------------- driver tasks (start and end on a negedge) ----------------
  task automatic do_lookup(input logic [5:0] idx, input logic [26:0] vpn, input logic [15:0] asid);
    bit got;
    got = 0;
    lkup_req = 1'b1; lkup_idx = idx; lkup_vpn = vpn; lkup_asid = asid;
    for (int c = 0; c < 200 && !got; c++) begin
      #1;
      if (lkup_gnt) begin
        got = 1;
        lk_gnt_cyc = cyc;
        lk_exp_q.push_back(m_lookup(idx, vpn, asid));
        lk_cyc_q.push_back(cyc + 2);
      end
      @(negedge forever_cpuclk);
    end
    lkup_req = 1'b0;
    check_eq("lkup_gnt", 128'(got), 128'd1);
  endtask

  task automatic do_refill(input logic [5:0] idx, input logic [47:0] tag);
    bit got;
    logic w;
    got = 0;
    w = 1'b0;
    refill_req = 1'b1; refill_idx = idx; refill_tag = tag;
    for (int c = 0; c < 200 && !got; c++) begin
      #1;
      if (refill_gnt) begin
        got = 1;
        rf_gnt_cyc = cyc;
        m_refill(idx, tag, w);
        rf_exp_q.push_back(w);
        rf_cyc_q.push_back(cyc + 2);
      end
      @(negedge forever_cpuclk);
    end
    refill_req = 1'b0;
    check_eq("refill_gnt", 128'(got), 128'd1);
    if (got) begin
      #1;
      check_eq("refill_write", {jtlb_tag_cen, jtlb_tag_wen, jtlb_tag_idx, jtlb_tag_din},
               {1'b1, 1'b1, w, ~w, 9'(idx), 1'b0, ~w, tag, tag});
      @(negedge forever_cpuclk);
    end
  endtask

  task automatic do_inv();
    bit got;
    got = 0;
    inv_all_req = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      #1;
      if (inv_all_gnt) begin
        got = 1;
        inv_gnt_cyc = cyc;
        m_clear();
      end
      @(negedge forever_cpuclk);
    end
    inv_all_req = 1'b0;
    check_eq("inv_gnt", 128'(got), 128'd1);
    if (got) begin
      for (int i = 0; i < 64; i++) begin
        #1;
        check_eq("inv_write", {jtlb_tag_cen, jtlb_tag_wen, jtlb_tag_idx, jtlb_tag_din},
                 {1'b1, 3'b111, 9'(i), 98'd0});
        if (i == 0) check_eq("inv_state", {ctrl_busy, ctrl_state_o}, {1'b1, 3'd4});
        @(negedge forever_cpuclk);
      end
      #1;
      check_eq("inv_done_pulse", inv_all_done, 1);
      check_eq("inv_done_delay", cyc - inv_gnt_cyc, 65);
      check_eq("inv_idle", ctrl_busy, 0);
      @(negedge forever_cpuclk);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [5:0] rnd_sets [6];
  int g0, snap;
  bit found;

  initial begin
    cpurst_b = 1'b0;
    lkup_req = 1'b0; lkup_idx = '0; lkup_vpn = '0; lkup_asid = '0;
    refill_req = 1'b0; refill_idx = '0; refill_tag = '0;
    inv_all_req = 1'b0;
    m_clear();
    rnd_sets = '{6'd5, 6'd9, 6'd10, 6'd11, 6'd12, 6'd20};
    repeat (3) @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    #1;
    check_eq("rst_array", {jtlb_tag_cen, jtlb_tag_wen, jtlb_tag_idx, jtlb_tag_din}, 0);
    check_eq("rst_pulses", {lkup_rslt_vld, refill_done, inv_all_done, ctrl_busy}, 0);
    check_eq("rst_result", {lkup_hit, lkup_hit_way, lkup_multi_hit, lkup_hit_tag, refill_way}, 0);
    check_eq("rst_state", ctrl_state_o, 0);
    @(negedge forever_cpuclk);

    do_inv();

    // First refill lands in way0 of an empty set; ASID must match for a non-global entry.
    do_refill(6'd5, mk_tag(1'b0, 2'b00, 16'd3, 27'h123));
    do_lookup(6'd5, 27'h123, 16'd3);
    g0 = lk_gnt_cyc;
    do_lookup(6'd5, 27'h123, 16'd4);
    check_eq("b2b_lookup_gap", lk_gnt_cyc - g0, 1);

    // FIFO replacement alternates once both ways are valid; a matching tag overrides FIFO.
    do_refill(6'd5, mk_tag(1'b0, 2'b00, 16'd3, 27'h456));
    do_refill(6'd5, mk_tag(1'b0, 2'b00, 16'd3, 27'h789));
    do_refill(6'd5, mk_tag(1'b0, 2'b00, 16'd3, 27'habc));
    do_refill(6'd5, mk_tag(1'b0, 2'b00, 16'd3, 27'habc));
    do_lookup(6'd5, 27'h123, 16'd3);
    do_lookup(6'd5, 27'h789, 16'd3);
    do_lookup(6'd5, 27'habc, 16'd3);

    // Page sizes and global entries.
    do_refill(6'd9, mk_tag(1'b1, 2'b01, 16'h77, 27'h200));
    do_lookup(6'd9, 27'h3ff, 16'h1234);
    do_lookup(6'd9, 27'h400, 16'h77);
    do_refill(6'd10, mk_tag(1'b1, 2'b00, 16'h77, 27'h200));
    do_lookup(6'd10, 27'h3ff, 16'h77);
    do_lookup(6'd10, 27'h200, 16'h1);
    do_refill(6'd11, mk_tag(1'b0, 2'b11, 16'd5, 27'h12345));
    do_lookup(6'd11, 27'h3ffff, 16'd5);
    do_lookup(6'd11, 27'h40000, 16'd5);

    // Two entries hitting the same VA: way0 reported, multi-hit flagged.
    do_refill(6'd12, mk_tag(1'b0, 2'b00, 16'd3, 27'h50));
    do_refill(6'd12, mk_tag(1'b1, 2'b00, 16'd7, 27'h50));
    do_lookup(6'd12, 27'h50, 16'd3);
    do_lookup(6'd12, 27'h50, 16'd9);

    // Simultaneous refill and lookup: refill wins, lookup follows two cycles later.
    fork
      do_refill(6'd20, mk_tag(1'b0, 2'b00, 16'd2, 27'h5555));
      do_lookup(6'd20, 27'h5555, 16'd2);
    join
    check_eq("refill_over_lookup", lk_gnt_cyc - rf_gnt_cyc, 2);

    for (int i = 0; i < 12; i++) begin
      logic [5:0]  s;
      logic [26:0] v;
      s = rnd_sets[$urandom_range(0, 5)];
      v = ($urandom_range(0, 1) == 1) ? m_w0[s][27:1] : 27'($urandom_range(0, 32'h3ff));
      do_lookup(s, v, 16'($urandom_range(0, 7)));
    end

    // Invalidate-all beats a pending lookup, which then misses everywhere.
    fork
      do_inv();
      do_lookup(6'd5, 27'h789, 16'd3);
    join
    check_eq("inv_over_lookup", lk_gnt_cyc - inv_gnt_cyc, 65);

    // Reset in the middle of a sweep.
    inv_all_req = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (inv_all_gnt) found = 1;
      @(negedge forever_cpuclk);
    end
    inv_all_req = 1'b0;
    check_eq("inv2_gnt", 128'(found), 128'd1);
    found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      #1;
      if (jtlb_tag_cen && jtlb_tag_wen == 3'b111 && jtlb_tag_idx == 9'd20) found = 1;
      else @(negedge forever_cpuclk);
    end
    check_eq("inv2_reach_20", 128'(found), 128'd1);
    snap = inv_done_cnt;
    cpurst_b = 1'b0;
    #1;
    check_eq("midrst_array", {jtlb_tag_cen, jtlb_tag_wen, jtlb_tag_idx, jtlb_tag_din}, 0);
    check_eq("midrst_state", {ctrl_busy, ctrl_state_o}, 0);
    check_eq("midrst_outs", {lkup_rslt_vld, refill_done, inv_all_done, lkup_hit_tag}, 0);
    repeat (2) @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    repeat (70) @(negedge forever_cpuclk);
    check_eq("midrst_no_done", inv_done_cnt, snap);
    do_inv();
    do_refill(6'd33, mk_tag(1'b0, 2'b00, 16'd1, 27'h1));
    do_lookup(6'd33, 27'h1, 16'd1);

    repeat (4) @(negedge forever_cpuclk);
    check_eq("lk_queue_drained", lk_exp_q.size(), 0);
    check_eq("rf_queue_drained", rf_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
